// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU opcode encodings, default latencies and op-class helpers.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by MDU_MADD_EN.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // Ops that occupy the unit for MULT_CYC cycles
  function automatic logic is_mul_class(input logic [3:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: returns the next {HI,LO} for a mult/div-class op.
// Divide by zero returns the current HI/LO; accumulate ops exist only with MDU_MADD_EN.
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_res
);

  logic [63:0] w_hilo;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_rs_abs, w_rt_abs, w_q_abs, w_r_abs;
  logic [31:0] w_q_s, w_r_s, w_q_u, w_r_u;

  assign w_hilo   = {i_hi, i_lo};
  assign w_prod_s = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
  assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

  // Signed divide via magnitudes so INT_MIN / -1 wraps instead of overflowing
  assign w_rs_abs = i_rs[31] ? (32'd0 - i_rs) : i_rs;
  assign w_rt_abs = i_rt[31] ? (32'd0 - i_rt) : i_rt;
  assign w_q_abs  = w_rs_abs / w_rt_abs;
  assign w_r_abs  = w_rs_abs % w_rt_abs;
  assign w_q_s    = (i_rs[31] ^ i_rt[31]) ? (32'd0 - w_q_abs) : w_q_abs;
  assign w_r_s    = i_rs[31] ? (32'd0 - w_r_abs) : w_r_abs;
  assign w_q_u    = i_rs / i_rt;
  assign w_r_u    = i_rs % i_rt;

  always_comb begin
    o_res = w_hilo;
    case (i_op)
      MD_MULT:  o_res = w_prod_s;
      MD_MULTU: o_res = w_prod_u;
      MD_DIV:   if (i_rt != 32'd0) o_res = {w_r_s, w_q_s};
      MD_DIVU:  if (i_rt != 32'd0) o_res = {w_r_u, w_q_u};
`ifdef MDU_MADD_EN
      MD_MADD:  o_res = w_hilo + w_prod_s;
      MD_MADDU: o_res = w_hilo + w_prod_u;
      MD_MSUB:  o_res = w_hilo - w_prod_s;
      MD_MSUBU: o_res = w_hilo - w_prod_u;
`endif
      default:  o_res = w_hilo;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: IDLE/RUN sequencer, busy counter, HI/LO and stall request.
// Accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MDU_MADD_EN is defined.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_md_op,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  input  logic        i_md_d,
  output logic        o_busy,
  output logic        o_stall_req,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic [31:0] o_md_rd
);

  mdu_state_e  r_state, w_state_nx;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic [31:0] r_hi, r_lo, r_hi_sh, r_lo_sh;
  logic [63:0] w_calc;
  logic        w_is_mul, w_is_div, w_load_sh, w_commit, w_mthi, w_mtlo;

  assign w_is_mul = is_mul_class(i_md_op);
  assign w_is_div = is_div_class(i_md_op);

  mdu_calc u_calc (
    .i_op  (i_md_op),
    .i_rs  (i_rs_val),
    .i_rt  (i_rt_val),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .o_res (w_calc)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_load_sh  = 1'b0;
    w_commit   = 1'b0;
    w_mthi     = 1'b0;
    w_mtlo     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_mthi = (i_md_op == MD_MTHI);
        w_mtlo = (i_md_op == MD_MTLO);
        if (w_is_mul || w_is_div) begin
          w_load_sh  = 1'b1;
          w_cnt_nx   = w_is_mul ? 4'(MULT_CYC) : 4'(DIV_CYC);
          w_state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == 4'd1) begin
          w_commit   = 1'b1;
          w_cnt_nx   = 4'd0;
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_hi_sh <= 32'd0;
      r_lo_sh <= 32'd0;
    end else begin
      if (w_load_sh) begin
        r_hi_sh <= w_calc[63:32];
        r_lo_sh <= w_calc[31:0];
      end
      if (w_commit) begin
        r_hi <= r_hi_sh;
        r_lo <= r_lo_sh;
      end
      if (w_mthi) r_hi <= i_rs_val;
      if (w_mtlo) r_lo <= i_rs_val;
    end
  end

  assign o_busy      = (r_state == ST_RUN);
  assign o_stall_req = i_md_d & (o_busy | w_is_mul | w_is_div);
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;
  assign o_md_rd     = (i_md_op == MD_MFHI) ? r_hi :
                       (i_md_op == MD_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed scoreboard bench for mdu_ctrl; the accumulate section follows MDU_MADD_EN.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_d;
  logic        busy, stall_req;
  logic [31:0] hi, lo, md_rd;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_hl;

  mdu_ctrl dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_md_op     (md_op),
    .i_rs_val    (rs_val),
    .i_rt_val    (rt_val),
    .i_md_d      (md_d),
    .o_busy      (busy),
    .o_stall_req (stall_req),
    .o_hi        (hi),
    .o_lo        (lo),
    .o_md_rd     (md_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a mult/div op at the current cycle and check busy length and HI/LO on completion.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic d, input logic [63:0] exp, input int cyc);
    logic [63:0] e;
    md_op = op; rs_val = rs; rt_val = rt; md_d = d;
    sb.push_back(exp);
    #1;
    check({tag, "_stall_issue"}, {31'd0, stall_req}, {31'd0, d});
    check({tag, "_busy_issue"}, {31'd0, busy}, 32'd0);
    step();
    md_op = MD_NONE; md_d = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      #1;
      check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
      step();
    end
    #1;
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_hi"}, hi, e[63:32]);
      check({tag, "_lo"}, lo, e[31:0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; md_op = MD_NONE; rs_val = '0; rt_val = '0; md_d = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_md_rd", md_rd, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    step();

    run_op("mult",  MD_MULT,  32'hFFFF_FFFF, 32'd2, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 5);
    // back-to-back: issued in the first cycle busy reads 0
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, {32'h0000_0001, 32'hFFFF_FFFE}, 5);
    run_op("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);
    run_op("divu0", MD_DIVU,  32'd7,         32'd0, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);
    run_op("divu",  MD_DIVU,  32'd100,       32'd7, 1'b1, {32'd2, 32'd14}, 10);
    step();

    // MULT in flight with an MDU op held in D every cycle
    md_op = MD_MULT; rs_val = 32'h0001_0000; rt_val = 32'h0001_0001; md_d = 1'b1;
    #1;
    check("stall_n", {31'd0, stall_req}, 32'd1);
    step();
    md_op = MD_NONE;
    for (int i = 1; i <= 5; i++) begin
      #1;
      check("stall_run", {31'd0, stall_req}, 32'd1);
      step();
    end
    md_op = MD_MFLO;
    #1;
    check("stall_n6", {31'd0, stall_req}, 32'd0);
    check("mflo_new", md_rd, 32'h0001_0000);
    check("mult_hi2", hi, 32'd1);
    md_op = MD_MFHI; md_d = 1'b0;
    #1;
    check("mfhi_new", md_rd, 32'd1);
    step();

    md_op = MD_MTHI; rs_val = 32'h1234_5678;
    #1;
    check("mthi_busy", {31'd0, busy}, 32'd0);
    step();
    md_op = MD_MTLO; rs_val = 32'h0000_0001;
    #1;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy_after", {31'd0, busy}, 32'd0);
    step();
    md_op = MD_NONE;
    #1;
    check("mtlo_lo", lo, 32'd1);
    check("none_md_rd", md_rd, 32'd0);
    step();

`ifdef MDU_MADD_EN
    md_op = MD_MTHI; rs_val = 32'd0;
    step();
    md_op = MD_NONE;
    run_op("madd", MD_MADD, 32'd3, 32'd3, 1'b1, {32'd0, 32'd10}, 5);
    run_op("msub", MD_MSUB, 32'd3, 32'd4, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 5);
    step();
`else
    md_op = MD_MADD; rs_val = 32'd3; rt_val = 32'd3; md_d = 1'b1;
    #1;
    check("madd_off_stall", {31'd0, stall_req}, 32'd0);
    check("madd_off_md_rd", md_rd, 32'd0);
    step();
    md_op = MD_NONE; md_d = 1'b0;
    #1;
    check("madd_off_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) step();
    #1;
    check("madd_off_hi", hi, 32'h1234_5678);
    check("madd_off_lo", lo, 32'd1);
    step();
`endif

    // reset during cycle N+3 of a DIV discards the pending result
    md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
    step();
    md_op = MD_NONE;
    step(); step();
    #1;
    check("rstdiv_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstdiv_busy", {31'd0, busy}, 32'd0);
    check("rstdiv_hi", hi, 32'd0);
    check("rstdiv_lo", lo, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("rstdiv_busy_after", {31'd0, busy}, 32'd0);
      step();
    end
    check("rstdiv_hi_after", hi, 32'd0);
    check("rstdiv_lo_after", lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
